vrb_arb2: RTL and testbench
===========================

VRB_ARB2 -- requirements
Module: vrb_arb2

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; the wmask width is DW/8.
REQ-003 SHALL have parameter OUTS, default 2, the maximum number of outstanding commands; legal values are 1, 2, 4 or 8.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have, for N=0 (IFU) and N=1 (LSU), port i_mN_cmd_valid, input, 1 bit: master command valid.
REQ-007 SHALL have port o_mN_cmd_ready, output, 1 bit: master command accepted.
REQ-008 SHALL have port i_mN_cmd_addr, input, AW bits.
REQ-009 SHALL have port i_mN_cmd_read, input, 1 bit.
REQ-010 SHALL have port i_mN_cmd_wdata, input, DW bits.
REQ-011 SHALL have port i_mN_cmd_wmask, input, DW/8 bits.
REQ-012 SHALL have port o_mN_rsp_valid, output, 1 bit.
REQ-013 SHALL have port i_mN_rsp_ready, input, 1 bit.
REQ-014 SHALL have port o_mN_rsp_err, output, 1 bit.
REQ-015 SHALL have port o_mN_rsp_rdata, output, DW bits.
REQ-016 SHALL have the shared-slave command ports: o_s_cmd_valid (output, 1), i_s_cmd_ready (input, 1), o_s_cmd_addr (output, AW), o_s_cmd_read (output, 1), o_s_cmd_wdata (output, DW), o_s_cmd_wmask (output, DW/8).
REQ-017 SHALL have the shared-slave response ports: i_s_rsp_valid (input, 1), o_s_rsp_ready (output, 1), i_s_rsp_err (input, 1), i_s_rsp_rdata (input, DW).
REQ-018 SHALL have port o_stray_rsp, output, 1 bit: one-cycle pulse when a response arrives with no command outstanding.

Function
REQ-019 SHALL pass commands through combinationally, with zero added latency; a command handshake occurs when o_s_cmd_valid and i_s_cmd_ready are both 1.
REQ-020 SHALL arbitrate round-robin: the requester other than the last one granted wins a tie; the last-granted register updates only on a command handshake.
REQ-021 SHALL lock the grant while o_s_cmd_valid=1 and i_s_cmd_ready=0, so the granted master and its command fields stay stable until the handshake.
REQ-022 SHALL drive o_s_cmd_valid = (granted master's valid) AND NOT full; when no master is granted, all o_s_cmd_* outputs are 0.
REQ-023 SHALL drive o_mN_cmd_ready = (grant==N) AND i_s_cmd_ready AND NOT full; the non-granted master's ready is 0.
REQ-024 SHALL push the granted master ID into an in-order FIFO of depth OUTS on each command handshake; full means count==OUTS.
REQ-025 SHALL route i_s_rsp_valid, i_s_rsp_err and i_s_rsp_rdata to the master at the FIFO head; o_s_rsp_ready = i_mN_rsp_ready of that master; the non-head master's rsp_valid is 0.
REQ-026 SHALL pop the FIFO on a response handshake; a push and a pop in the same cycle leave the count unchanged, pointers wrap modulo OUTS, and a full FIFO with a pop accepts no new command in that cycle.
REQ-027 SHALL, when count==0 and i_s_rsp_valid=1, drive o_s_rsp_ready=1, drive both o_mN_rsp_valid=0, and pulse o_stray_rsp for one cycle.
REQ-028 SHALL allow a response for a command accepted in cycle t no earlier than cycle t+1 (no same-cycle command and response pass-through).

Reset
REQ-029 SHALL, while rst_n=0 at a rising clk edge, clear the FIFO count and pointers, clear the lock, and set last-granted to 0 (IFU), so that LSU wins the first tie.
REQ-030 SHALL, during and after reset, hold o_mN_cmd_ready=0, o_mN_rsp_valid=0, o_s_cmd_valid=0 and o_stray_rsp=0 until inputs request otherwise; a reset mid-transaction discards all outstanding IDs.

Structure
REQ-031 SHALL take AW, DW and the master-ID encoding (IFU=0, LSU=1) from the shared config package/include; no new typedefs are required.
REQ-032 SHALL implement the ID FIFO as one sub-module, vrb_id_fifo (parameters OUTS and width 1).

Verification
REQ-033 SHALL cover a tie after reset: both masters valid, i_s_cmd_ready=1 -> LSU granted in cycle 0, IFU in cycle 1, alternating thereafter.
REQ-034 SHALL cover a held-off slave: IFU valid, i_s_cmd_ready=0 for 3 cycles with LSU raising valid in cycle 1 -> the grant stays IFU with a stable addr until the handshake in cycle 3.
REQ-035 SHALL cover a full FIFO: OUTS=2, two commands accepted with no responses -> o_s_cmd_valid=0 and both readies=0; after one response the third command is accepted the next cycle.
REQ-036 SHALL cover out-of-master-order responses: IFU addr 0x100 then LSU addr 0x2000 accepted, responses rdata 0xA then 0xB -> IFU receives 0xA, LSU receives 0xB, and err is routed likewise.
REQ-037 SHALL cover a stray response and reset: i_s_rsp_valid with count=0 -> o_stray_rsp=1 for one cycle; rst_n=0 with 2 commands outstanding -> count=0 the next cycle and all valids 0.

Source files
------------

// File: rtl/vrb_arb2_pkg.sv
// rtl/vrb_arb2_pkg.sv - shared widths, master IDs and round-robin pick for the two-master arbiter
package vrb_arb2_pkg;

  localparam int   VRB_AW = 32;
  localparam int   VRB_DW = 32;
  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  // On a tie the master that was not granted last wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    else if (v1)  return ID_LSU;
    else          return ID_IFU;
  endfunction

endpackage

// File: rtl/vrb_id_fifo.sv
// rtl/vrb_id_fifo.sv - in-order FIFO of master IDs for outstanding commands
module vrb_id_fifo #(
  parameter int OUTS = 2,
  parameter int W    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS + 1);

  logic [W-1:0]  mem [OUTS];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(OUTS));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vrb_arb2.sv
// rtl/vrb_arb2.sv - round-robin arbiter of IFU/LSU onto one slave with in-order response routing
module vrb_arb2
  import vrb_arb2_pkg::*;
#(
  parameter int AW   = VRB_AW,
  parameter int DW   = VRB_DW,
  parameter int OUTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_m0_cmd_valid,
  output logic              o_m0_cmd_ready,
  input  logic [AW-1:0]     i_m0_cmd_addr,
  input  logic              i_m0_cmd_read,
  input  logic [DW-1:0]     i_m0_cmd_wdata,
  input  logic [DW/8-1:0]   i_m0_cmd_wmask,
  output logic              o_m0_rsp_valid,
  input  logic              i_m0_rsp_ready,
  output logic              o_m0_rsp_err,
  output logic [DW-1:0]     o_m0_rsp_rdata,
  input  logic              i_m1_cmd_valid,
  output logic              o_m1_cmd_ready,
  input  logic [AW-1:0]     i_m1_cmd_addr,
  input  logic              i_m1_cmd_read,
  input  logic [DW-1:0]     i_m1_cmd_wdata,
  input  logic [DW/8-1:0]   i_m1_cmd_wmask,
  output logic              o_m1_rsp_valid,
  input  logic              i_m1_rsp_ready,
  output logic              o_m1_rsp_err,
  output logic [DW-1:0]     o_m1_rsp_rdata,
  output logic              o_s_cmd_valid,
  input  logic              i_s_cmd_ready,
  output logic [AW-1:0]     o_s_cmd_addr,
  output logic              o_s_cmd_read,
  output logic [DW-1:0]     o_s_cmd_wdata,
  output logic [DW/8-1:0]   o_s_cmd_wmask,
  input  logic              i_s_rsp_valid,
  output logic              o_s_rsp_ready,
  input  logic              i_s_rsp_err,
  input  logic [DW-1:0]     i_s_rsp_rdata,
  output logic              o_stray_rsp
);

  logic lock_q, lock_id_q, last_q;
  logic gnt_vld, gnt_id, gnt_req;
  logic cmd_hs, rsp_hit, rsp_pop;
  logic head_id, fifo_empty, fifo_full;

  // While a command is stalled the grant is frozen so its fields stay stable.
  always_comb begin
    gnt_vld = lock_q | i_m0_cmd_valid | i_m1_cmd_valid;
    gnt_id  = lock_q ? lock_id_q : rr_pick(i_m0_cmd_valid, i_m1_cmd_valid, last_q);
    gnt_req = (gnt_id == ID_LSU) ? i_m1_cmd_valid : i_m0_cmd_valid;
  end

  always_comb begin
    o_s_cmd_addr  = '0;
    o_s_cmd_read  = 1'b0;
    o_s_cmd_wdata = '0;
    o_s_cmd_wmask = '0;
    if (gnt_vld) begin
      if (gnt_id == ID_LSU) begin
        o_s_cmd_addr  = i_m1_cmd_addr;
        o_s_cmd_read  = i_m1_cmd_read;
        o_s_cmd_wdata = i_m1_cmd_wdata;
        o_s_cmd_wmask = i_m1_cmd_wmask;
      end else begin
        o_s_cmd_addr  = i_m0_cmd_addr;
        o_s_cmd_read  = i_m0_cmd_read;
        o_s_cmd_wdata = i_m0_cmd_wdata;
        o_s_cmd_wmask = i_m0_cmd_wmask;
      end
    end
  end

  assign o_s_cmd_valid  = rst_n & gnt_vld & gnt_req & ~fifo_full;
  assign o_m0_cmd_ready = rst_n & gnt_vld & (gnt_id == ID_IFU) & i_s_cmd_ready & ~fifo_full;
  assign o_m1_cmd_ready = rst_n & gnt_vld & (gnt_id == ID_LSU) & i_s_cmd_ready & ~fifo_full;
  assign cmd_hs         = o_s_cmd_valid & i_s_cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_IFU;
      last_q    <= ID_IFU;
    end else begin
      lock_q <= o_s_cmd_valid & ~i_s_cmd_ready;
      if (o_s_cmd_valid && !i_s_cmd_ready) lock_id_q <= gnt_id;
      if (cmd_hs) last_q <= gnt_id;
    end
  end

  // The head ID is registered, so a response can never bypass its own command.
  assign rsp_hit       = i_s_rsp_valid & ~fifo_empty;
  assign o_s_rsp_ready = fifo_empty ? 1'b1 : ((head_id == ID_LSU) ? i_m1_rsp_ready : i_m0_rsp_ready);
  assign rsp_pop       = rsp_hit & o_s_rsp_ready;
  assign o_stray_rsp   = rst_n & i_s_rsp_valid & fifo_empty;

  assign o_m0_rsp_valid = rst_n & rsp_hit & (head_id == ID_IFU);
  assign o_m1_rsp_valid = rst_n & rsp_hit & (head_id == ID_LSU);
  assign o_m0_rsp_err   = ~fifo_empty & (head_id == ID_IFU) & i_s_rsp_err;
  assign o_m1_rsp_err   = ~fifo_empty & (head_id == ID_LSU) & i_s_rsp_err;
  assign o_m0_rsp_rdata = (~fifo_empty && head_id == ID_IFU) ? i_s_rsp_rdata : '0;
  assign o_m1_rsp_rdata = (~fifo_empty && head_id == ID_LSU) ? i_s_rsp_rdata : '0;

  vrb_id_fifo #(
    .OUTS (OUTS),
    .W    (1)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_hs),
    .din   (gnt_id),
    .pop   (rsp_pop),
    .dout  (head_id),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_vrb_arb2.sv
// tb/tb_vrb_arb2.sv - directed scoreboard bench for vrb_arb2
module tb_vrb_arb2;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct { logic read; logic [AW-1:0] addr; } cmd_t;
  typedef struct { logic id; logic err; logic [DW-1:0] rdata; } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [AW-1:0] m0_cmd_addr, m1_cmd_addr, s_cmd_addr;
  logic [DW-1:0] m0_cmd_wdata, m1_cmd_wdata, m0_rsp_rdata, m1_rsp_rdata, s_cmd_wdata, s_rsp_rdata;
  logic [DW/8-1:0] m0_cmd_wmask, m1_cmd_wmask, s_cmd_wmask;
  logic s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready, s_rsp_err, stray_rsp;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic done   = 1'b0;

  always #5 clk = ~clk;

  vrb_arb2 #(.AW(AW), .DW(DW), .OUTS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m0_cmd_valid(m0_cmd_valid), .o_m0_cmd_ready(m0_cmd_ready), .i_m0_cmd_addr(m0_cmd_addr),
    .i_m0_cmd_read(m0_cmd_read), .i_m0_cmd_wdata(m0_cmd_wdata), .i_m0_cmd_wmask(m0_cmd_wmask),
    .o_m0_rsp_valid(m0_rsp_valid), .i_m0_rsp_ready(m0_rsp_ready), .o_m0_rsp_err(m0_rsp_err),
    .o_m0_rsp_rdata(m0_rsp_rdata),
    .i_m1_cmd_valid(m1_cmd_valid), .o_m1_cmd_ready(m1_cmd_ready), .i_m1_cmd_addr(m1_cmd_addr),
    .i_m1_cmd_read(m1_cmd_read), .i_m1_cmd_wdata(m1_cmd_wdata), .i_m1_cmd_wmask(m1_cmd_wmask),
    .o_m1_rsp_valid(m1_rsp_valid), .i_m1_rsp_ready(m1_rsp_ready), .o_m1_rsp_err(m1_rsp_err),
    .o_m1_rsp_rdata(m1_rsp_rdata),
    .o_s_cmd_valid(s_cmd_valid), .i_s_cmd_ready(s_cmd_ready), .o_s_cmd_addr(s_cmd_addr),
    .o_s_cmd_read(s_cmd_read), .o_s_cmd_wdata(s_cmd_wdata), .o_s_cmd_wmask(s_cmd_wmask),
    .i_s_rsp_valid(s_rsp_valid), .o_s_rsp_ready(s_rsp_ready), .i_s_rsp_err(s_rsp_err),
    .i_s_rsp_rdata(s_rsp_rdata), .o_stray_rsp(stray_rsp)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_c(input logic id, input logic [AW-1:0] addr);
    cmd_t c;
    c.read = (id == 1'b0);
    c.addr = addr;
    exp_cmd.push_back(c);
  endtask

  task automatic exp_r(input logic id, input logic err, input logic [DW-1:0] rdata);
    rsp_t r;
    r.id = id; r.err = err; r.rdata = rdata;
    exp_rsp.push_back(r);
  endtask

  task automatic rsp_check(input logic id, input logic err, input logic [DW-1:0] rdata);
    rsp_t r;
    if (exp_rsp.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_unexpected: got master %0d rdata 0x%0h expected none", id, rdata);
    end else begin
      r = exp_rsp.pop_front();
      chk("rsp_master", 64'(id), 64'(r.id));
      chk("rsp_err_rdata", {31'd0, err, rdata}, {31'd0, r.err, r.rdata});
    end
  endtask

  // Monitor: every handshake seen at the DUT is matched against the scoreboard.
  always @(negedge clk) begin
    cmd_t c;
    if (rst_n && !done) begin
      if (s_cmd_valid && s_cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cmd_unexpected: got addr 0x%0h expected none", s_cmd_addr);
        end else begin
          c = exp_cmd.pop_front();
          chk("cmd_read_addr", {31'd0, s_cmd_read, s_cmd_addr}, {31'd0, c.read, c.addr});
        end
      end
      if (m0_rsp_valid && m0_rsp_ready) rsp_check(1'b0, m0_rsp_err, m0_rsp_rdata);
      if (m1_rsp_valid && m1_rsp_ready) rsp_check(1'b1, m1_rsp_err, m1_rsp_rdata);
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic rsp(input logic v, input logic err, input logic [DW-1:0] d);
    s_rsp_valid = v; s_rsp_err = err; s_rsp_rdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_cmd_valid = 0; m0_cmd_addr = 32'h100; m0_cmd_read = 1; m0_cmd_wdata = 0; m0_cmd_wmask = 0;
    m1_cmd_valid = 0; m1_cmd_addr = 32'h2000; m1_cmd_read = 0; m1_cmd_wdata = 32'h5A5A; m1_cmd_wmask = 4'hF;
    m0_rsp_ready = 1; m1_rsp_ready = 1; s_cmd_ready = 0;
    rsp(0, 0, 0);
    nxt(); nxt();
    @(negedge clk);
    chk("rst_s_cmd_valid", 64'(s_cmd_valid), 0);
    chk("rst_cmd_ready", {m0_cmd_ready, m1_cmd_ready}, 0);
    chk("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    chk("rst_stray", 64'(stray_rsp), 0);
    nxt();
    rst_n = 1'b1;

    // Tie after reset: LSU first, then alternating, responses one cycle behind.
    m0_cmd_valid = 1; m1_cmd_valid = 1; s_cmd_ready = 1;
    exp_c(1, 32'h2000);
    @(negedge clk);
    chk("tie0_ready", {m0_cmd_ready, m1_cmd_ready}, 2'b01);
    nxt(); exp_c(0, 32'h100);  rsp(1, 0, 32'h1); exp_r(1, 0, 32'h1);
    @(negedge clk);
    chk("tie1_ready", {m0_cmd_ready, m1_cmd_ready}, 2'b10);
    nxt(); exp_c(1, 32'h2000); rsp(1, 0, 32'h2); exp_r(0, 0, 32'h2);
    nxt(); exp_c(0, 32'h100);  rsp(1, 0, 32'h3); exp_r(1, 0, 32'h3);
    nxt(); m0_cmd_valid = 0; m1_cmd_valid = 0; rsp(1, 0, 32'h4); exp_r(0, 0, 32'h4);
    nxt(); rsp(0, 0, 0);

    // Held-off slave: IFU stays granted while LSU joins.
    nxt(); m0_cmd_valid = 1; s_cmd_ready = 0;
    @(negedge clk);
    chk("hold0_valid_addr", {31'd0, s_cmd_valid, s_cmd_addr}, {31'd0, 1'b1, 32'h100});
    nxt(); m1_cmd_valid = 1;
    @(negedge clk);
    chk("hold1_addr", 64'(s_cmd_addr), 64'h100);
    chk("hold1_ready", {m0_cmd_ready, m1_cmd_ready}, 0);
    nxt();
    @(negedge clk);
    chk("hold2_addr", 64'(s_cmd_addr), 64'h100);
    nxt(); s_cmd_ready = 1; exp_c(0, 32'h100);
    @(negedge clk);
    chk("hold3_ready", {m0_cmd_ready, m1_cmd_ready}, 2'b10);
    nxt(); m0_cmd_valid = 0; exp_c(1, 32'h2000);

    // FIFO full with IFU/LSU outstanding.
    nxt(); m1_cmd_valid = 0; m0_cmd_valid = 1; m0_cmd_addr = 32'h140;
    @(negedge clk);
    chk("full_valid", 64'(s_cmd_valid), 0);
    chk("full_ready", {m0_cmd_ready, m1_cmd_ready}, 0);
    nxt(); rsp(1, 0, 32'hA); exp_r(0, 0, 32'hA);
    @(negedge clk);
    chk("full_pop_valid", 64'(s_cmd_valid), 0);
    nxt(); rsp(0, 0, 0); exp_c(0, 32'h140);
    @(negedge clk);
    chk("after_pop_ready", 64'(m0_cmd_ready), 1);
    nxt(); m0_cmd_valid = 0; rsp(1, 1, 32'hB); exp_r(1, 1, 32'hB);
    @(negedge clk);
    chk("lsu_rsp_m0_valid", 64'(m0_rsp_valid), 0);
    nxt(); rsp(1, 0, 32'hC); exp_r(0, 0, 32'hC);
    nxt(); rsp(0, 0, 0);

    // Stray response with nothing outstanding.
    nxt(); m0_rsp_ready = 0; m1_rsp_ready = 0; rsp(1, 0, 32'hDEAD);
    @(negedge clk);
    chk("stray_pulse", {stray_rsp, s_rsp_ready}, 2'b11);
    chk("stray_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    nxt(); rsp(0, 0, 0); m0_rsp_ready = 1; m1_rsp_ready = 1;
    @(negedge clk);
    chk("stray_clear", 64'(stray_rsp), 0);

    // Reset with two commands outstanding discards them.
    nxt(); m0_cmd_valid = 1; m0_cmd_addr = 32'h300; exp_c(0, 32'h300);
    nxt(); exp_c(0, 32'h300);
    nxt(); rst_n = 0;
    @(negedge clk);
    chk("midrst_valids", {s_cmd_valid, m0_cmd_ready, m0_rsp_valid, m1_rsp_valid, stray_rsp}, 0);
    nxt(); rst_n = 1; m0_cmd_valid = 0; rsp(1, 0, 32'h77);
    @(negedge clk);
    chk("postrst_stray", {stray_rsp, m0_rsp_valid, m1_rsp_valid}, 3'b100);
    nxt(); rsp(0, 0, 0); m0_cmd_valid = 1; m0_cmd_addr = 32'h400; exp_c(0, 32'h400);
    @(negedge clk);
    chk("postrst_ready", 64'(m0_cmd_ready), 1);
    nxt(); m0_cmd_valid = 0; rsp(1, 0, 32'h55); exp_r(0, 0, 32'h55);
    nxt(); rsp(0, 0, 0);
    nxt();
    @(negedge clk);
    chk("cmd_queue_drained", 64'(exp_cmd.size()), 0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
